// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice.
// Holds the datapath widths, the MEM-stage FSM states and the alignment helper.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // A word access is legal only on a 4-byte boundary.
    function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge data-memory port between the MEM stage (master) and memory (slave).
interface mem_stage_if;
    import mips_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB payload register: enabled load, bubble insertion that clears only the
// control bits, and an independent enable for the read-data field.
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  bubble,
    input  logic                  load_rdata,
    input  logic                  regwrite_d,
    input  logic                  memtoreg_d,
    input  logic [REG_ADDR_W-1:0] wn_d,
    input  logic [WORD_W-1:0]     alu_d,
    input  logic [WORD_W-1:0]     rdata_d,
    output logic                  regwrite_q,
    output logic                  memtoreg_q,
    output logic [REG_ADDR_W-1:0] wn_q,
    output logic [WORD_W-1:0]     alu_q,
    output logic [WORD_W-1:0]     rdata_q
);

    // Payload register; a bubble leaves wn/alu/rdata untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            wn_q       <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
        end else if (en) begin
            if (bubble) begin
                regwrite_q <= 1'b0;
                memtoreg_q <= 1'b0;
            end else begin
                regwrite_q <= regwrite_d;
                memtoreg_q <= memtoreg_d;
                wn_q       <= wn_d;
                alu_q      <= alu_d;
            end
            if (load_rdata) begin
                rdata_q <= rdata_d;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM-stage controller: issues data-memory requests, stalls upstream while an
// access is outstanding, aborts on timeout and produces the MEM/WB payload.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  Branch,
    input  logic                  RegWrite,
    input  logic                  MemtoReg,
    input  logic                  zero,
    input  logic [REG_ADDR_W-1:0] wn,
    input  logic [WORD_W-1:0]     total_alu_out,
    input  logic [WORD_W-1:0]     rfile_rd2,
    output logic                  stall,
    output logic                  pcsrc,
    mem_stage_if.master           mem,
    output logic                  RegWrite_wb,
    output logic                  MemtoReg_wb,
    output logic [REG_ADDR_W-1:0] wn_wb,
    output logic [WORD_W-1:0]     alu_wb,
    output logic [WORD_W-1:0]     rdata_wb,
    output logic                  misalign,
    output logic                  bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_r, state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic                  mem_req_r, mem_we_r;
    logic [WORD_W-1:0]     mem_addr_r, mem_wdata_r;
    logic                  lat_regwrite_r, lat_memtoreg_r;
    logic [REG_ADDR_W-1:0] lat_wn_r;
    logic                  misalign_r, bus_err_r;

    logic                  mem_op_s, stall_s;
    logic                  issue_s, reject_s, done_s, abort_s;
    logic                  wb_en_s, wb_bubble_s, wb_load_rdata_s;
    logic                  wb_regwrite_s, wb_memtoreg_s;
    logic [REG_ADDR_W-1:0] wb_wn_s;
    logic [WORD_W-1:0]     wb_alu_s;

    assign mem_op_s = MemRead | MemWrite;

    // Next-state, stall and MEM/WB load control.
    always_comb begin
        state_nxt_s     = state_r;
        stall_s         = 1'b0;
        issue_s         = 1'b0;
        reject_s        = 1'b0;
        done_s          = 1'b0;
        abort_s         = 1'b0;
        wb_en_s         = 1'b0;
        wb_bubble_s     = 1'b0;
        wb_load_rdata_s = 1'b0;
        wb_regwrite_s   = RegWrite;
        wb_memtoreg_s   = MemtoReg;
        wb_wn_s         = wn;
        wb_alu_s        = total_alu_out;
        case (state_r)
            IDLE: begin
                wb_en_s = 1'b1;
                if (mem_op_s) begin
                    wb_bubble_s = 1'b1;
                    if (is_aligned(total_alu_out)) begin
                        stall_s     = 1'b1;
                        issue_s     = 1'b1;
                        state_nxt_s = ACCESS;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    wb_bubble_s = 1'b0;
                end
            end
            ACCESS: begin
                // An ack in the final counted cycle still completes normally.
                if (mem.mem_ack) begin
                    done_s          = 1'b1;
                    wb_en_s         = 1'b1;
                    wb_regwrite_s   = lat_regwrite_r;
                    wb_memtoreg_s   = lat_memtoreg_r;
                    wb_wn_s         = lat_wn_r;
                    wb_alu_s        = mem_addr_r;
                    wb_load_rdata_s = ~mem_we_r;
                    state_nxt_s     = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    stall_s     = 1'b1;
                    abort_s     = 1'b1;
                    wb_en_s     = 1'b1;
                    wb_bubble_s = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request registers, latched control and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= '0;
            mem_wdata_r    <= '0;
            lat_regwrite_r <= 1'b0;
            lat_memtoreg_r <= 1'b0;
            lat_wn_r       <= '0;
            cnt_r          <= '0;
        end else if (issue_s) begin
            mem_req_r      <= 1'b1;
            mem_we_r       <= MemWrite;
            mem_addr_r     <= total_alu_out;
            mem_wdata_r    <= rfile_rd2;
            lat_regwrite_r <= RegWrite;
            lat_memtoreg_r <= MemtoReg;
            lat_wn_r       <= wn;
            cnt_r          <= '0;
        end else if (done_s || abort_s) begin
            mem_req_r <= 1'b0;
        end else if (state_r == ACCESS) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Status flags: one-cycle misalign pulse and sticky bus error.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_r <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            misalign_r <= reject_s;
            bus_err_r  <= bus_err_r | abort_s;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .en         (wb_en_s),
        .bubble     (wb_bubble_s),
        .load_rdata (wb_load_rdata_s),
        .regwrite_d (wb_regwrite_s),
        .memtoreg_d (wb_memtoreg_s),
        .wn_d       (wb_wn_s),
        .alu_d      (wb_alu_s),
        .rdata_d    (mem.mem_rdata),
        .regwrite_q (RegWrite_wb),
        .memtoreg_q (MemtoReg_wb),
        .wn_q       (wn_wb),
        .alu_q      (alu_wb),
        .rdata_q    (rdata_wb)
    );

    assign stall         = stall_s;
    assign pcsrc         = Branch & zero;
    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign misalign      = misalign_r;
    assign bus_err       = bus_err_r;

endmodule

// File: doc/mem_stage.md
# mem_stage

MEM-stage controller of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs and drives a request/acknowledge data-memory port. It holds upstream stages with a stall while an access is outstanding, resolves branches, and produces the registered MEM/WB payload for write-back.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles in ACCESS without `mem_ack` before abort; must be ≥ 1.
- `CNT_W`, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `MemRead`, `MemWrite`, `Branch`, `RegWrite`, `MemtoReg`  in  1 each  control bits from EX/MEM
- `zero`  in  1  ALU zero flag from EX/MEM
- `wn`  in  5  destination register number
- `total_alu_out`  in  32  ALU result / memory byte address
- `rfile_rd2`  in  32  store data
- `stall`  out  1  high: upstream `en_reg` must be low this cycle
- `pcsrc`  out  1  branch taken, = `Branch & zero` (combinational)
- `mem_req`, `mem_we`  out  1 each  memory request, write enable (registered)
- `mem_addr`, `mem_wdata`  out  32 each  registered address and write data
- `mem_rdata`  in  32  read data, valid when `mem_ack`
- `mem_ack`  in  1  one-cycle completion pulse
- `RegWrite_wb`, `MemtoReg_wb`  out  1 each  MEM/WB control
- `wn_wb`  out  5; `alu_wb`, `rdata_wb`  out  32  MEM/WB payload
- `misalign`  out  1  one-cycle pulse on rejected unaligned access
- `bus_err`  out  1  sticky timeout flag, cleared only by `rst`

## Operation
- "mem op" = `MemRead | MemWrite`. If both bits are high, the access is treated as a write.
- FSM states: IDLE, ACCESS.
- IDLE, no mem op:
  - MEM/WB loads `RegWrite`, `MemtoReg`, `wn`, `total_alu_out` at the next edge.
  - `rdata_wb` holds its previous value.
  - `stall` = 0.
- IDLE, mem op with `total_alu_out[1:0] != 0`:
  - No request is issued; `misalign` pulses high for the next cycle.
  - MEM/WB loads a bubble: `RegWrite_wb` = 0, `MemtoReg_wb` = 0, other fields unchanged.
  - `stall` = 0.
- IDLE, aligned mem op:
  - `stall` = 1 combinationally.
  - Next edge: latch control, `wn`, and address; `mem_req` ← 1, `mem_we` ← `MemWrite`, `mem_addr` ← `total_alu_out`, `mem_wdata` ← `rfile_rd2`; counter ← 0; go to ACCESS.
  - MEM/WB loads a bubble.
- ACCESS:
  - `stall` = 1 except in the cycle where `mem_ack` = 1.
  - The `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` outputs are stable until ack or abort.
  - Counter increments each cycle without ack.
  - On `mem_ack`: MEM/WB loads the latched control, `wn`, and address; `rdata_wb` ← `mem_rdata` for reads, unchanged for writes; `mem_req` ← 0; go to IDLE.
  - On counter = TIMEOUT−1 without ack: `mem_req` ← 0, `bus_err` ← 1, MEM/WB loads a bubble, go to IDLE.
  - Ack wins over timeout if both occur in the same cycle.
- `mem_ack` in IDLE (late or spurious) is ignored.
- `pcsrc` is independent of state. Upstream holds EX/MEM stable while `stall` = 1, so `pcsrc` remains valid.
- Reset: state IDLE; every output register is 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, all `*_wb`, `misalign`, `bus_err`); counter 0. Reset during ACCESS drops `mem_req` at that edge.

## Timing
- Non-memory instruction: MEM/WB valid 1 edge after EX/MEM presents it.
- Memory op: `mem_req` rises at edge 1. If ack arrives in the same cycle, MEM/WB is valid at edge 2. Stall lasts for cycles 0..k, where k is the ack latency after request.
- Minimum memory-op cost: 1 stall cycle.
- Timeout: `mem_req` high for exactly TIMEOUT cycles, then `bus_err` is set at the following edge.
- `misalign` is high for exactly 1 cycle per rejected instruction.

## Structure
- Shared package `mips_pkg`: state enum {IDLE, ACCESS}, `WORD_W` = 32, `REG_ADDR_W` = 5.
- Sub-module `mem_wb_reg`: plain enabled MEM/WB payload register with synchronous reset; the FSM drives its enable and bubble select.
- The FSM, timeout counter, and request registers remain in `mem_stage`.

## Test plan
- R-type pass-through: `RegWrite`=1, `wn`=5'd9, `total_alu_out`=32'h0000_0040, no mem op. Expect `alu_wb`=32'h40, `wn_wb`=9, `RegWrite_wb`=1 after 1 edge; `stall` never asserted.
- Load with 3-cycle ack: `MemRead`=1, address 32'h100, `mem_rdata`=32'hDEAD_BEEF. Expect `mem_addr`=32'h100 with `mem_we`=0, and `stall` high for 3 cycles. Expect `rdata_wb`=32'hDEADBEEF, `MemtoReg_wb`=1 on the edge after ack.
- Store with same-cycle ack: address 32'h8, data 32'h1234. Expect `mem_we`=1, `mem_wdata`=32'h1234, `stall` high for 1 cycle, `rdata_wb` unchanged.
- Misaligned load at 32'h102: expect no `mem_req`, `misalign` pulse for 1 cycle, `RegWrite_wb`=0.
- Timeout with `TIMEOUT`=4 and no ack: expect `mem_req` high for 4 cycles, then `bus_err`=1 (sticky), bubble written. A later ack is ignored.
- Branch and reset: `Branch`=1, `zero`=1 gives `pcsrc`=1 immediately. Asserting `rst` mid-ACCESS gives `mem_req`=0 and all outputs 0 at that edge.
